// File: rtl/apb_gpio_arbiter.sv
// Two-requester round-robin APB master for the GPIO slave port.
// Runs SETUP/ACCESS with a PREADY timeout and per-requester responses.
module apb_gpio_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  addr0,
  input  logic [3:0]  addr1,
  input  logic        write0,
  input  logic        write1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        busy,
  output logic [3:0]  PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [1:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_RESP
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_owner;
  logic       r_last;
  logic [7:0] r_cnt;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_tmo;

  // r_last names the requester granted most recently; ties go to the other one.
  assign w_gnt0 = req0 & (~req1 | r_last);
  assign w_gnt1 = req1 & (~req0 | ~r_last);
  assign w_tmo  = (r_cnt == LP_LAST);

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; PREADY matters only in ACCESS.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (req0 | req1) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (PREADY | w_tmo) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus strobes and status decoded from state only.
  always_comb begin
    PSEL    = (r_state == S_SETUP) | (r_state == S_ACCESS);
    PENABLE = (r_state == S_ACCESS);
    busy    = (r_state != S_IDLE);
    done0   = (r_state == S_RESP) & ~r_owner;
    done1   = (r_state == S_RESP) & r_owner;
  end

  // Grant latch, timeout counter and per-requester responses.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 8'd0;
      PADDR   <= 4'd0;
      PWRITE  <= 1'b0;
      PWDATA  <= 32'd0;
      rdata0  <= 32'd0;
      rdata1  <= 32'd0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt0) begin
            PADDR   <= addr0;
            PWRITE  <= write0;
            PWDATA  <= wdata0;
            r_owner <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_gnt1) begin
            PADDR   <= addr1;
            PWRITE  <= write1;
            PWDATA  <= wdata1;
            r_owner <= 1'b1;
            r_last  <= 1'b1;
          end
        end
        S_SETUP: r_cnt <= 8'd0;
        S_ACCESS: begin
          if (PREADY) begin
            if (!PWRITE && !r_owner) rdata0 <= PRDATA;
            if (!PWRITE && r_owner)  rdata1 <= PRDATA;
            if (!r_owner) err0 <= 1'b0;
            else          err1 <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_tmo && !r_owner) err0 <= 1'b1;
            if (w_tmo && r_owner)  err1 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Directed bench for apb_gpio_arbiter with a small GPIO slave stub.
// Covers write/read timing, round-robin, timeout, stale PREADY, reset.
module tb_apb_gpio_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req0, req1;
  logic [3:0]  addr0, addr1;
  logic        write0, write1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        busy;
  logic [3:0]  PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;

  logic [31:0] cr, odr, pins;
  logic        r_rdy_auto;
  logic        man_rdy;
  int          mode;
  int          n_run = 0;
  int          n_fail = 0;

  apb_gpio_arbiter #(.TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .write0(write0), .write1(write1),
    .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Slave stub: registered PREADY one cycle into ACCESS, or forced modes.
  assign PREADY = (mode == 0) ? r_rdy_auto :
                  (mode == 2) ? man_rdy : 1'b0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_rdy_auto <= 1'b0;
    else        r_rdy_auto <= PSEL & PENABLE & ~r_rdy_auto;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cr  <= 32'd0;
      odr <= 32'd0;
    end else if (PSEL && PENABLE && PREADY && PWRITE) begin
      if (PADDR == 4'h0) cr  <= PWDATA;
      if (PADDR == 4'h4) odr <= PWDATA;
    end
  end

  always_comb begin
    PRDATA = 32'hDEAD_BEEF;
    if (PADDR == 4'h0) PRDATA = cr;
    if (PADDR == 4'h4) PRDATA = odr;
    if (PADDR == 4'h8) PRDATA = pins;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // Raise one request, count cycles until its done, then drop it.
  task automatic run(input bit who, input logic [3:0] a, input bit w,
                     input logic [31:0] d, output int n);
    if (who) begin
      req1 = 1'b1; addr1 = a; write1 = w; wdata1 = d;
    end else begin
      req0 = 1'b1; addr0 = a; write0 = w; wdata0 = d;
    end
    n = 0;
    while (!(who ? done1 : done0) && n < 64) begin
      tick();
      n++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    PRESET = 1'b1;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    write0 = 0; write1 = 0; wdata0 = 0; wdata1 = 0;
    mode = 0; man_rdy = 0; pins = 32'd0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_psel", PSEL, 0);
    check("rst_pen", PENABLE, 0);
    check("rst_busy", busy, 0);
    check("rst_done", {done1, done0}, 0);
    check("rst_err", {err1, err0}, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_rdata0", rdata0, 0);
    PRESET = 1'b0;

    // Write requester 0, cycle-by-cycle.
    req0 = 1; addr0 = 4'h0; write0 = 1; wdata0 = 32'h0000_00FF;
    check("w_c0_psel", PSEL, 0);
    tick();
    check("w_c1_sel", {PSEL, PENABLE}, 2'b10);
    tick();
    check("w_c2_sel", {PSEL, PENABLE}, 2'b11);
    tick();
    check("w_c3_sel", {PSEL, PENABLE}, 2'b11);
    check("w_c3_done", done0, 0);
    tick();
    check("w_c4_done", {done1, done0}, 2'b01);
    check("w_c4_err", err0, 0);
    check("w_c4_psel", PSEL, 0);
    check("w_cr", cr, 32'h0000_00FF);
    req0 = 0;
    tick();
    check("w_c5_done", done0, 0);
    check("w_c5_busy", busy, 0);
    check("w_hold_paddr", {PWRITE, PADDR}, 5'h10);

    // Read requester 1 from IDR after clearing CR.
    run(0, 4'h0, 1, 32'd0, n);
    check("cr_clr_lat", n, 4);
    pins = 32'h0000_1234;
    run(1, 4'h8, 0, 32'd0, n);
    check("r_lat", n, 4);
    check("r_rdata1", rdata1, 32'h0000_1234);
    check("r_err1", err1, 0);
    check("r_rdata0", rdata0, 0);

    // Contention from reset: 0,1,0,1 every 5 cycles.
    PRESET = 1'b1;
    tick();
    req0 = 1; addr0 = 4'h8; write0 = 0;
    req1 = 1; addr1 = 4'h4; write1 = 0;
    PRESET = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check($sformatf("rr_c%0d", c), {done1, done0},
            (c == 4 || c == 14) ? 2'b01 :
            (c == 9 || c == 19) ? 2'b10 : 2'b00);
      if (c == 19) begin
        req0 = 0;
        req1 = 0;
      end
      tick();
    end
    check("rr_rdata0", rdata0, 32'h0000_1234);
    check("rr_idle", busy, 0);

    // Timeout: PREADY held low.
    mode = 1;
    run(0, 4'h0, 0, 32'd0, n);
    check("to_lat", n, 18);
    check("to_err0", err0, 1);
    check("to_rdata0", rdata0, 32'h0000_1234);
    check("to_idle", busy, 0);
    tick();
    check("to_err_hold", err0, 1);

    // Stale PREADY in IDLE/SETUP must be ignored.
    mode = 2;
    man_rdy = 1;
    req0 = 1; addr0 = 4'h0; write0 = 0;
    tick();
    check("st_c1_sel", {PSEL, PENABLE}, 2'b10);
    tick();
    man_rdy = 0;
    check("st_c2_done", done0, 0);
    tick();
    check("st_c3_done", done0, 0);
    check("st_c3_pen", PENABLE, 1);
    tick();
    check("st_c4_done", done0, 0);
    man_rdy = 1;
    tick();
    check("st_c5_done", done0, 1);
    check("st_c5_err", err0, 0);
    check("st_rdata0", rdata0, 0);
    req0 = 0;
    man_rdy = 0;
    mode = 0;
    tick();
    tick();

    // Reset during ACCESS.
    req0 = 1; addr0 = 4'h4; write0 = 1; wdata0 = 32'h0000_00AA;
    tick();
    tick();
    check("ra_pen", PENABLE, 1);
    PRESET = 1'b1;
    #1;
    check("ra_sel", {PSEL, PENABLE, busy}, 3'b000);
    check("ra_paddr", PADDR, 0);
    check("ra_pwdata", PWDATA, 0);
    check("ra_pwrite", PWRITE, 0);
    for (int c = 0; c < 3; c++) begin
      check("ra_nodone", {done1, done0}, 0);
      tick();
    end
    req1 = 1; addr1 = 4'h0; write1 = 0;
    PRESET = 1'b0;
    n = 0;
    while (!(done0 | done1) && n < 32) begin
      tick();
      n++;
    end
    check("ra_tie_lat", n, 4);
    check("ra_tie_win", {done1, done0}, 2'b01);
    req0 = 0;
    req1 = 0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
